// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, opcode constants, mux/ALU/immediate codes, ALUOp type,
// and a helper that says whether a func3 has a supported ALU operation.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_MDR       = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMMEXT    = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_REG   = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_BRANCH = 2'd1,
    ALUOP_FUNC   = 2'd2
  } aluop_t;

  // True for the func3 values the ALU decoder maps to a real operation.
  function automatic logic func3_supported(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
           (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// Latency: n/a (wires only).
// Backpressure: none; the controller advances every cycle.
// master = controller (reads instruction fields/flags, drives controls);
// slave = datapath. illegal_instr exists only with MCCTRL_ILLEGAL_TRAP_EN.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       branchLEG;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic [3:0] state_o;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
    input  op, func3, func7, zero, branchLEG,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state_o
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    , output illegal_instr
`endif
  );

  modport slave (
    output op, func3, func7, zero, branchLEG,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state_o
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    , input illegal_instr
`endif
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps ALUOp class + func fields to ALUControl.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_aluop (class), i_func3, i_func7b5, i_op5 (R-type marker) -> o_alucontrol.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [2:0] i_func3,
  input  logic       i_func7b5,
  input  logic       i_op5,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    unique case (i_aluop)
      ALUOP_ADD:    o_alucontrol = ALU_ADD;
      // blt/bge (func3[2]=1) compare with slt, beq/bne with sub.
      ALUOP_BRANCH: o_alucontrol = i_func3[2] ? ALU_SLT : ALU_SUB;
      ALUOP_FUNC: begin
        case (i_func3)
          // Only R-type honours func7[5]; addi's immediate can set that bit.
          3'b000:  o_alucontrol = (i_op5 && i_func7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alucontrol = ALU_SLT;
          3'b100:  o_alucontrol = ALU_XOR;
          3'b110:  o_alucontrol = ALU_OR;
          3'b111:  o_alucontrol = ALU_AND;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default:      o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for the multicycle RV32I datapath (R/I-ALU, lw, sw, branches, jal, jalr, lui).
// Latency: outputs combinational from state; lw 5, sw 4, R/I 4, branch 3, lui 3, jal 4, jalr 5 cycles.
// Backpressure: none; one state per cycle, reset returns to FETCH immediately.
// Ports: clk, rst_n (async active-low), bus (multicycle_controller_if.master).
// Optional: MCCTRL_ILLEGAL_TRAP_EN sends unknown opcodes / unsupported func3 to HALT.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        bus
);

  state_t     r_state;
  state_t     w_next_state;
  aluop_t     w_aluop;
  logic       w_pcwrite;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_adrsrc;
  logic [1:0] w_resultsrc;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;
  logic [2:0] w_immsrc;
  logic [2:0] w_alucontrol;
  logic       w_illegal;
  logic       w_unused_func7;

  assign w_unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= state_t'(RESET_STATE);
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_aluop      = ALUOP_ADD;
    w_pcwrite    = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_regwrite   = 1'b0;
    w_adrsrc     = 1'b0;
    w_resultsrc  = RES_ALUOUT;
    w_srca       = SRCA_PC;
    w_srcb       = SRCB_REG;
    w_immsrc     = IMM_I;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite    = 1'b1;
        w_srcb       = SRCB_FOUR;
        w_resultsrc  = RES_ALURESULT;
        w_pcwrite    = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC+imm into ALUOut: branch/jal targets use it later.
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        case (bus.op)
          OP_STORE:  w_immsrc = IMM_S;
          OP_BRANCH: w_immsrc = IMM_B;
          OP_JAL:    w_immsrc = IMM_J;
          OP_LUI:    w_immsrc = IMM_U;
          default:   w_immsrc = IMM_I;
        endcase
        case (bus.op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXEC_R;
          OP_ITYPE:          w_next_state = S_EXEC_I;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR_ADR;
          OP_LUI:            w_next_state = S_LUI;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
          default:           w_next_state = S_HALT;
`else
          default:           w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_srca       = SRCA_REG;
        w_srcb       = SRCB_IMM;
        w_immsrc     = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        w_next_state = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adrsrc     = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc  = RES_MDR;
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adrsrc     = 1'b1;
        w_memwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        w_srca       = SRCA_REG;
        w_srcb       = (r_state == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
        w_aluop      = ALUOP_FUNC;
        w_next_state = S_ALUWB;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        if (!func3_supported(bus.func3)) w_next_state = S_HALT;
`endif
      end
      S_ALUWB: begin
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_srca       = SRCA_REG;
        w_srcb       = SRCB_REG;
        w_immsrc     = IMM_B;
        w_aluop      = ALUOP_BRANCH;
        // func3[2] picks the flag (slt vs equality), func3[0] inverts it.
        w_pcwrite    = (bus.func3[2] ? bus.branchLEG : bus.zero) ^ bus.func3[0];
        w_next_state = S_FETCH;
      end
      S_JAL, S_JALR_PC: begin
        // PC <= target held in ALUOut while the ALU forms the link value OldPC+4.
        w_pcwrite    = 1'b1;
        w_srca       = SRCA_OLDPC;
        w_srcb       = SRCB_FOUR;
        w_next_state = S_ALUWB;
      end
      S_JALR_ADR: begin
        w_srca       = SRCA_REG;
        w_srcb       = SRCB_IMM;
        w_next_state = S_JALR_PC;
      end
      S_LUI: begin
        w_immsrc     = IMM_U;
        w_resultsrc  = RES_IMMEXT;
        w_regwrite   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        w_illegal    = 1'b1;
        w_next_state = S_HALT;
`else
        w_next_state = S_FETCH;
`endif
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_func3      (bus.func3),
    .i_func7b5    (bus.func7[5]),
    .i_op5        (bus.op[5]),
    .o_alucontrol (w_alucontrol)
  );

  // Reset forces every control to zero even though r_state already reads FETCH.
  assign bus.PCWrite    = rst_n & w_pcwrite;
  assign bus.IRWrite    = rst_n & w_irwrite;
  assign bus.MemWrite   = rst_n & w_memwrite;
  assign bus.RegWrite   = rst_n & w_regwrite;
  assign bus.AdrSrc     = rst_n & w_adrsrc;
  assign bus.ResultSrc  = rst_n ? w_resultsrc  : 2'd0;
  assign bus.ALUSrcA    = rst_n ? w_srca       : 2'd0;
  assign bus.ALUSrcB    = rst_n ? w_srcb       : 2'd0;
  assign bus.ALUControl = rst_n ? w_alucontrol : 3'd0;
  assign bus.ImmSrc     = rst_n ? w_immsrc     : 3'd0;
  assign bus.state_o    = r_state;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = rst_n & w_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instructions, per-cycle expected controls.
// Latency: n/a. Backpressure: n/a.
// Stimulus pushes one expected control vector per cycle; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  multicycle_controller_if ifc ();

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [21:0] exp_q[$];
  string       name_q[$];

  // {illegal, state, PCWrite IRWrite MemWrite RegWrite AdrSrc, ResultSrc, SrcA, SrcB, ALUControl, ImmSrc}
  function automatic logic [21:0] v(input logic [3:0] st, input logic [4:0] en,
                                    input logic [1:0] rs, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [2:0] alu,
                                    input logic [2:0] imm);
    return {1'b0, st, en, rs, sa, sb, alu, imm};
  endfunction

  function automatic logic [21:0] actual();
    logic ill;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ill = ifc.illegal_instr;
`else
    ill = 1'b0;
`endif
    return {ill, ifc.state_o, ifc.PCWrite, ifc.IRWrite, ifc.MemWrite, ifc.RegWrite,
            ifc.AdrSrc, ifc.ResultSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl, ifc.ImmSrc};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      logic [21:0] a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    failures++;
    $display("FAIL timeout: stimulus did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string n);
    checks++;
    if (ifc.state_o !== 4'd0 || ifc.PCWrite !== 1'b0 || ifc.IRWrite !== 1'b0 ||
        ifc.MemWrite !== 1'b0 || ifc.RegWrite !== 1'b0) begin
        failures++;
        $display("FAIL %s: state=%0d PCWrite=%b IRWrite=%b MemWrite=%b RegWrite=%b", n,
                 ifc.state_o, ifc.PCWrite, ifc.IRWrite, ifc.MemWrite, ifc.RegWrite);
    end
  endtask

  task automatic expect_v(input string n, input logic [21:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input logic leg);
    ifc.op = op; ifc.func3 = f3; ifc.func7 = f7; ifc.zero = z; ifc.branchLEG = leg;
  endtask

  task automatic go(input int n);
    repeat (n) tick();
  endtask

  localparam logic [21:0] ZERO = 22'd0;
  localparam logic [21:0] VF   = {1'b0, 4'd0, 5'b11000, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0};
  localparam logic [21:0] VW   = {1'b0, 4'd8, 5'b00010, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0};

  task automatic r_op(input string n, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [2:0] alu);
    set_in(7'b0110011, f3, f7, 1'b0, 1'b0);
    expect_v({n, "_fetch"}, VF);
    expect_v({n, "_decode"}, v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd0));
    expect_v({n, "_exec"}, v(4'd6, 5'b0, 2'd0, 2'd2, 2'd0, alu, 3'd0));
    expect_v({n, "_wb"}, VW);
    go(4);
  endtask

  task automatic i_op(input string n, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [2:0] alu);
    set_in(7'b0010011, f3, f7, 1'b0, 1'b0);
    expect_v({n, "_fetch"}, VF);
    expect_v({n, "_decode"}, v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd0));
    expect_v({n, "_exec"}, v(4'd7, 5'b0, 2'd0, 2'd2, 2'd1, alu, 3'd0));
    expect_v({n, "_wb"}, VW);
    go(4);
  endtask

  task automatic br_op(input string n, input logic [2:0] f3, input logic z, input logic leg,
                       input logic pcw, input logic [2:0] alu);
    set_in(7'b1100011, f3, 7'd0, z, leg);
    expect_v({n, "_fetch"}, VF);
    expect_v({n, "_decode"}, v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd2));
    expect_v({n, "_branch"}, v(4'd9, {pcw, 4'b0}, 2'd0, 2'd2, 2'd0, alu, 3'd2));
    go(3);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    expect_v("reset_0", ZERO);
    expect_v("reset_1", ZERO);
    go(3);
    check_reset_state("reset_state_initial");
    rst_n = 1'b1;

    // lw: 5 cycles
    set_in(7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0);
    expect_v("lw_fetch", VF);
    expect_v("lw_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd0));
    expect_v("lw_memadr", v(4'd2, 5'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    expect_v("lw_memread", v(4'd3, 5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    expect_v("lw_memwb", v(4'd4, 5'b00010, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0));
    go(5);

    // sw: 4 cycles, MemWrite exactly once
    set_in(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    expect_v("sw_fetch", VF);
    expect_v("sw_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd1));
    expect_v("sw_memadr", v(4'd2, 5'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
    expect_v("sw_memwrite", v(4'd5, 5'b00101, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    go(4);

    r_op("add", 3'b000, 7'h00, 3'b000);
    r_op("sub", 3'b000, 7'h20, 3'b001);
    r_op("xor", 3'b100, 7'h00, 3'b100);
    r_op("or",  3'b110, 7'h00, 3'b011);
    r_op("and", 3'b111, 7'h00, 3'b010);
    r_op("slt", 3'b010, 7'h00, 3'b101);
    i_op("addi_f7hi", 3'b000, 7'h20, 3'b000);
    i_op("xori", 3'b100, 7'h00, 3'b100);
    i_op("andi", 3'b111, 7'h00, 3'b010);
`ifndef MCCTRL_ILLEGAL_TRAP_EN
    i_op("slli_as_add", 3'b001, 7'h00, 3'b000);
`endif

    br_op("beq_z1", 3'b000, 1'b1, 1'b0, 1'b1, 3'b001);
    br_op("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0, 3'b001);
    br_op("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0, 3'b001);
    br_op("blt_l1", 3'b100, 1'b0, 1'b1, 1'b1, 3'b101);
    br_op("bge_l1", 3'b101, 1'b0, 1'b1, 1'b0, 3'b101);

    // jal: 4 cycles
    set_in(7'b1101111, 3'b000, 7'd0, 1'b0, 1'b0);
    expect_v("jal_fetch", VF);
    expect_v("jal_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd3));
    expect_v("jal_jal", v(4'd10, 5'b10000, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0));
    expect_v("jal_wb", VW);
    go(4);

    // jalr: 5 cycles
    set_in(7'b1100111, 3'b000, 7'd0, 1'b0, 1'b0);
    expect_v("jalr_fetch", VF);
    expect_v("jalr_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd0));
    expect_v("jalr_adr", v(4'd11, 5'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    expect_v("jalr_pc", v(4'd12, 5'b10000, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0));
    expect_v("jalr_wb", VW);
    go(5);

    // lui: 3 cycles
    set_in(7'b0110111, 3'b000, 7'd0, 1'b0, 1'b0);
    expect_v("lui_fetch", VF);
    expect_v("lui_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd4));
    expect_v("lui_lui", v(4'd13, 5'b00010, 2'd3, 2'd0, 2'd0, 3'd0, 3'd4));
    go(3);

    // sw interrupted by reset in the middle of MEMWRITE
    set_in(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    expect_v("rst_sw_fetch", VF);
    expect_v("rst_sw_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd1));
    expect_v("rst_sw_memadr", v(4'd2, 5'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
    go(3);
    expect_v("rst_sw_memwrite", v(4'd5, 5'b00101, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    #6;
    rst_n = 1'b0;
    expect_v("mid_reset_0", ZERO);
    expect_v("mid_reset_1", ZERO);
    expect_v("mid_reset_2", ZERO);
    go(4);
    check_reset_state("reset_state_mid_memwrite");
    rst_n = 1'b1;
    set_in(7'b0110111, 3'b000, 7'd0, 1'b0, 1'b0);
    expect_v("post_rst_fetch", VF);
    expect_v("post_rst_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd4));
    expect_v("post_rst_lui", v(4'd13, 5'b00010, 2'd3, 2'd0, 2'd0, 3'd0, 3'd4));
    go(3);

    // unknown opcode
    set_in(7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0);
    expect_v("illop_fetch", VF);
    expect_v("illop_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd0));
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    expect_v("halt_0", {1'b1, 4'd14, 17'd0});
    expect_v("halt_1", {1'b1, 4'd14, 17'd0});
    expect_v("halt_2", {1'b1, 4'd14, 17'd0});
    go(5);
`else
    go(2);
    set_in(7'b0110111, 3'b000, 7'd0, 1'b0, 1'b0);
    expect_v("after_nop_fetch", VF);
    expect_v("after_nop_decode", v(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd4));
    go(2);
`endif

    go(1);
    checks++;
    if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain: %0d expected vectors never compared", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
